// File: rtl/rom_bus_arbiter_pkg.sv
// Shared types and the address-window check for the ROM data-bus arbiter.
package rom_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_e;
  typedef enum logic {GRANT_CPU, GRANT_DMA} arb_grant_e;

  // Misaligned or outside [base, base+bytes); the offset wraps so addresses below base fault too.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (off >= bytes);
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_rr2.sv
// Combinational two-way round-robin picker: on contention the requester
// that did not win last time is chosen.
module rom_arb_rr2
  import rom_arb_pkg::*;
(
  input  logic       cpuValid,
  input  logic       dmaValid,
  input  arb_grant_e lastGrant,
  output logic       grantValid,
  output arb_grant_e grant
);

  always_comb begin
    grantValid = cpuValid | dmaValid;
    grant      = GRANT_CPU;
    if (cpuValid && dmaValid) begin
      grant = (lastGrant == GRANT_DMA) ? GRANT_CPU : GRANT_DMA;
    end else if (dmaValid) begin
      grant = GRANT_DMA;
    end
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Arbitrates CPU and DMA reads onto the ROM's combinational data port and
// returns a registered word plus fault flag to the granted requester.
module rom_bus_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpuReqValid,
  output logic        cpuReqReady,
  input  logic [31:0] cpuReqAddr,
  output logic        cpuRespValid,
  input  logic        cpuRespReady,
  output logic [31:0] cpuRespData,
  output logic        cpuRespErr,
  input  logic        dmaReqValid,
  output logic        dmaReqReady,
  input  logic [31:0] dmaReqAddr,
  output logic        dmaRespValid,
  input  logic        dmaRespReady,
  output logic [31:0] dmaRespData,
  output logic        dmaRespErr,
  output logic [31:0] busReadAddress,
  input  logic [31:0] busReadData
);

  arb_state_e  r_state;
  arb_state_e  w_next;
  arb_grant_e  r_last_grant;
  logic [31:0] r_data;
  logic        r_err;

  logic        w_grant_valid;
  arb_grant_e  w_grant;
  logic [31:0] w_win_addr;
  logic        w_fault;
  logic        w_take;

  rom_arb_rr2 u_rr2 (
    .cpuValid   (cpuReqValid),
    .dmaValid   (dmaReqValid),
    .lastGrant  (r_last_grant),
    .grantValid (w_grant_valid),
    .grant      (w_grant)
  );

  assign w_win_addr = (w_grant == GRANT_CPU) ? cpuReqAddr : dmaReqAddr;
  assign w_fault    = addr_fault(w_win_addr, ROM_BASE, 32'(ROM_BYTES));

  always_comb begin
    w_next         = r_state;
    w_take         = 1'b0;
    cpuReqReady    = 1'b0;
    dmaReqReady    = 1'b0;
    busReadAddress = '0;
    cpuRespValid   = 1'b0;
    cpuRespData    = '0;
    cpuRespErr     = 1'b0;
    dmaRespValid   = 1'b0;
    dmaRespData    = '0;
    dmaRespErr     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_valid) begin
          busReadAddress = w_win_addr;
          cpuReqReady    = (w_grant == GRANT_CPU);
          dmaReqReady    = (w_grant == GRANT_DMA);
          w_take         = 1'b1;
          w_next         = ARB_RESP;
        end
      end
      ARB_RESP: begin
        // The last grant doubles as the owner of the pending response.
        if (r_last_grant == GRANT_CPU) begin
          cpuRespValid = 1'b1;
          cpuRespData  = r_data;
          cpuRespErr   = r_err;
          if (cpuRespReady) w_next = ARB_IDLE;
        end else begin
          dmaRespValid = 1'b1;
          dmaRespData  = r_data;
          dmaRespErr   = r_err;
          if (dmaRespReady) w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_DMA;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_last_grant <= w_grant;
        r_err        <= w_fault;
        r_data       <= w_fault ? '0 : busReadData;
      end
    end
  end

endmodule

// File: doc/rom_bus_arbiter.md
# rom_bus_arbiter

Two-requester arbiter and sequencer for the instruction ROM's data-bus read port. It lets the CPU load/store unit and the DMA engine read ROM constants through the single combinational `busReadAddress`/`busReadData` port. It applies round-robin arbitration, registers the returned word, and flags misaligned or out-of-window accesses. It sits between the data-bus interconnect and the ROM; the instruction-fetch port is not involved.

## Interface
- `ROM_BASE`, default 32'h0000_0000: byte base address of the ROM window.
- `ROM_BYTES`, default 4096: window size in bytes; power of two; 1024 words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpuReqValid`  in  1  CPU read request.
- `cpuReqReady`  out  1  CPU request accepted this cycle.
- `cpuReqAddr`  in  32  CPU byte address.
- `cpuRespValid`  out  1  CPU response available.
- `cpuRespReady`  in  1  CPU takes the response.
- `cpuRespData`  out  32  CPU read word.
- `cpuRespErr`  out  1  CPU access fault.
- `dmaReqValid`, `dmaReqReady`, `dmaReqAddr`, `dmaRespValid`, `dmaRespReady`, `dmaRespData`, `dmaRespErr`: same directions, widths and meanings, for the DMA engine.
- `busReadAddress`  out  32  address to the ROM data port.
- `busReadData`  in  32  combinational ROM word for `busReadAddress`.

## Operation
- FSM states: IDLE and RESP.
- **IDLE:**
  - If no request is valid, both readies are 0 and `busReadAddress` = 0.
  - Otherwise a winner is picked. If only one requester is valid, it wins.
  - If both are valid, the requester other than `lastGrant` wins.
  - The winner's ready = 1 (combinational); the loser's ready = 0. `busReadAddress` = winner's address.
  - On handshake: capture `busReadData` and the error flag, set `lastGrant` = winner, go to RESP.
- **Error rule:**
  - err = (addr[1:0] != 0) OR (addr − ROM_BASE ≥ ROM_BYTES), evaluated as an unsigned 32-bit compare.
  - On err, captured data = 0.
- **RESP:**
  - Winner's `RespValid` = 1 with the registered data and err. Both `ReqReady` = 0. `busReadAddress` = 0.
  - When the winner's `RespReady` = 1, go to IDLE. The response is held stable until then.
- A response is delivered only to the requester that was granted.
- The other requester's valid and address are ignored until the next IDLE.
- **Requester rules:**
  - Hold valid and address stable until ready.
  - Requesters may withdraw valid before ready; the arbiter reacts immediately (combinational).
- `lastGrant` resets to DMA, so the CPU wins the first simultaneous request.

## Timing
- **Reset values:** all readies, `RespValid`, `RespData` and `RespErr` = 0; `busReadAddress` = 0; state IDLE; `lastGrant` = DMA.
- Request handshake in cycle T → `RespValid` = 1 from T+1.
- Response accepted in cycle R → state IDLE at R+1. The earliest next `ReqReady` is at R+1.
- Peak throughput: one transaction per 2 cycles.
- `RespReady` held high before the response → the response still lasts exactly one cycle.
- Reset asserted mid-RESP: the response is discarded and all outputs return to reset values immediately (asynchronous).
- Simultaneous valid: the grant alternates each transaction while both stay valid, so neither requester starves.

## Structure
- Package `rom_arb_pkg`:
  - `arb_state_e` enum {ARB_IDLE, ARB_RESP}.
  - `arb_grant_e` enum {GRANT_CPU, GRANT_DMA}.
  - Address-check helper function.
- Sub-module `rom_arb_rr2`: combinational 2-way round-robin picker. Inputs: two valids and `lastGrant`. Outputs: `grantValid` and `grant`.
- Top level holds the FSM, the data/err/grant registers and the muxing.

## Test plan
- **Single CPU read:** CPU reads 0x0000_0010 with ROM word 4 = 0xDEADBEEF → `cpuReqReady` at T; at T+1 `cpuRespValid` = 1, data 0xDEADBEEF, err 0; DMA outputs stay 0.
- **Simultaneous requests:** both valid (CPU 0x0, DMA 0x4) from reset → CPU served first, then DMA. Repeat the pair → CPU, DMA again, strictly alternating.
- **Back-pressure:** DMA `dmaRespReady` held 0 for 5 cycles → `dmaRespValid`/data stable throughout. `cpuReqReady` stays 0 until the cycle after acceptance.
- **Faults:** address 0x0000_0002 → err 1, data 0. Address 0x0000_1000 → err 1, data 0. Address 0x0000_0FFC → err 0.
- **Reset mid-response:** `rst_n` pulsed low during RESP → `cpuRespValid` drops without waiting for the clock; after release the next simultaneous request grants the CPU.
